id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
//  ID/EX pipeline register plus EX-side operand forwarding and load-use hazard detection.
//  Sits directly upstream of the ALU: registers decoded operands/controls, then drives aluInA,
//  aluInB, aluOp with the freshest value from EX/MEM or MEM/WB. Flags load-use stalls to IF/ID.
//  Injects bubbles on stall and on flush.
// PARAMETERS
//  DATA_W      32  operand/result width
//  REG_ADDR_W  5   register-file address width
// PORTS
//  clk            in   1          clock, all state updates on rising edge
//  rst            in   1          synchronous, active-high reset
//  idValid        in   1          ID holds a real instruction
//  idRs,idRt      in   REG_ADDR_W source register numbers
//  idDest         in   REG_ADDR_W destination register (already rd/rt-selected in ID)
//  idRsData       in   DATA_W     register-file read data for rs
//  idRtData       in   DATA_W     register-file read data for rt
//  idImm          in   DATA_W     sign-extended immediate
//  idAluOp        in   3          ALU opcode (add/sub/and/or/slt)
//  idAluSrc       in   1          1: aluInB = immediate, 0: aluInB = forwarded rt
//  idRegWrite     in   1          writes a register
//  idMemRead      in   1          load
//  idMemWrite     in   1          store
//  flush          in   1          squash the instruction entering EX (taken branch/jump)
//  exHold         in   1          downstream freeze: keep ID/EX contents unchanged
//  exMemRegWrite  in   1          EX/MEM instruction writes a register
//  exMemDest      in   REG_ADDR_W EX/MEM destination
//  exMemResult    in   DATA_W     EX/MEM ALU result
//  memWbRegWrite  in   1          MEM/WB instruction writes a register
//  memWbDest      in   REG_ADDR_W MEM/WB destination
//  memWbResult    in   DATA_W     MEM/WB write-back value
//  stall          out  1          load-use hazard: hold PC and IF/ID this cycle (combinational)
//  aluInA,aluInB  out  DATA_W     ALU operands (combinational from registered state + forwards)
//  aluOp          out  3          registered ALU opcode
//  exStoreData    out  DATA_W     forwarded rt value for stores
//  exDest         out  REG_ADDR_W registered destination
//  exValid,exRegWrite,exMemRead,exMemWrite  out 1  registered controls
// BEHAVIOUR
//  Reset: all registered fields 0 -> exValid/exRegWrite/exMemRead/exMemWrite=0, aluOp=000,
//   exDest=0, so aluInA=0, aluInB=0, exStoreData=0 unless forwarded.
//  Load-use: stall = idValid & exValid & exMemRead & exDest!=0 & (exDest==idRs | exDest==idRt).
//   exHold=1 forces stall=0 (stage frozen anyway).
//  Update priority each edge: rst > exHold (keep all) > flush|stall (bubble) > load ID fields.
//   Bubble: exValid, exRegWrite, exMemRead, exMemWrite cleared, exDest=0; data fields don't-care.
//   A loaded instruction with idValid=0 is loaded as a bubble.
//  Latency: ID fields visible at ALU inputs one cycle after capture; stall lasts exactly 1 cycle
//   per load-use (the load leaves EX on the next edge).
//  Forwarding (per operand rs/rt, from registered exRs/exRt):
//   EX/MEM if exMemRegWrite & exMemDest!=0 & exMemDest==src; else MEM/WB if memWbRegWrite &
//   memWbDest!=0 & memWbDest==src; else registered register-file data. EX/MEM wins when both match.
//   Register 0 never forwarded. aluInB = exAluSrc ? exImm : fwdRt; exStoreData = fwdRt always.
//  Register file is write-first; no forwarding into ID is done here.
//  Flush and stall together -> single bubble, stall still asserted. exHold and flush together -> hold.
// STRUCTURE
//  mips_pkg: ALU opcode constants (ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011,
//   ALU_SLT=100), DATA_W/REG_ADDR_W defaults, REG_ZERO=0, id_ex_t struct of registered fields.
//  Sub-module forwarding_unit: combinational, one instance per operand (src, both write ports ->
//   2-bit select); registers and hazard logic stay in the top.
// TESTING
//  1 rst=1 two cycles with valid ID inputs -> exValid=0, controls 0, aluOp=000, aluInA=aluInB=0.
//  2 EX/MEM rd=3 result 0x10, EX rs=3 rsData 0x99 -> aluInA=0x10; rd=0 with regWrite, data 0xFF -> no forward.
//  3 EX/MEM rd=5=0xA and MEM/WB rd=5=0xB, EX rt=5 aluSrc=0 -> aluInB=0xA, exStoreData=0xA.
//  4 lw rd=2 in EX, ID rs=2 -> stall=1 one cycle; next edge exValid=0; following cycle forward 0xB
//    via MEM/WB once load result arrives with memWbDest=2.
//  5 flush=1 and stall=1 same cycle -> one bubble, exRegWrite=0; exHold=1 with flush=1 -> contents unchanged.
//  6 aluSrc=1 idImm=0xFFFFFFFC -> aluInB=0xFFFFFFFC, exStoreData still forwarded rt.

Source files
------------

// File: rtl/mips_pkg.sv
// ============================================================================
//  Package     : mips_pkg
//  Description : Shared widths, ALU opcodes, forwarding selects and the
//                ID/EX register layout for the EX operand stage.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_EXMEM   = 2'b01,
    FWD_MEMWB   = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic                  valid;
    logic                  regWrite;
    logic                  memRead;
    logic                  memWrite;
    logic [2:0]            aluOp;
    logic                  aluSrc;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     rsData;
    logic [DATA_W-1:0]     rtData;
    logic [DATA_W-1:0]     imm;
  } id_ex_t;

endpackage

`default_nettype wire

// File: rtl/forwarding_unit.sv
// ============================================================================
//  Module      : forwarding_unit
//  Description : Picks the freshest source for one EX operand (EX/MEM first).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module forwarding_unit
  import mips_pkg::*;
#(
  parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  exMemRegWrite,
  input  logic [REG_ADDR_W-1:0] exMemDest,
  input  logic                  memWbRegWrite,
  input  logic [REG_ADDR_W-1:0] memWbDest,
  output fwd_sel_e              sel
);

  logic w_exMemHit;
  logic w_memWbHit;

  // r0 is hardwired, so a write to it must never shadow the register file
  assign w_exMemHit = exMemRegWrite && (exMemDest != '0) && (exMemDest == src);
  assign w_memWbHit = memWbRegWrite && (memWbDest != '0) && (memWbDest == src);

  always_comb begin
    sel = FWD_REGFILE;
    if (w_exMemHit) begin
      sel = FWD_EXMEM;
    end else if (w_memWbHit) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
// ============================================================================
//  Module      : id_ex_operand_stage
//  Description : ID/EX pipeline register with EX operand forwarding and
//                load-use stall detection feeding the ALU.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex_operand_stage
  import mips_pkg::*;
#(
  parameter int DATA_W     = mips_pkg::DATA_W,
  parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  idValid,
  input  logic [REG_ADDR_W-1:0] idRs,
  input  logic [REG_ADDR_W-1:0] idRt,
  input  logic [REG_ADDR_W-1:0] idDest,
  input  logic [DATA_W-1:0]     idRsData,
  input  logic [DATA_W-1:0]     idRtData,
  input  logic [DATA_W-1:0]     idImm,
  input  logic [2:0]            idAluOp,
  input  logic                  idAluSrc,
  input  logic                  idRegWrite,
  input  logic                  idMemRead,
  input  logic                  idMemWrite,
  input  logic                  flush,
  input  logic                  exHold,
  input  logic                  exMemRegWrite,
  input  logic [REG_ADDR_W-1:0] exMemDest,
  input  logic [DATA_W-1:0]     exMemResult,
  input  logic                  memWbRegWrite,
  input  logic [REG_ADDR_W-1:0] memWbDest,
  input  logic [DATA_W-1:0]     memWbResult,
  output logic                  stall,
  output logic [DATA_W-1:0]     aluInA,
  output logic [DATA_W-1:0]     aluInB,
  output logic [2:0]            aluOp,
  output logic [DATA_W-1:0]     exStoreData,
  output logic [REG_ADDR_W-1:0] exDest,
  output logic                  exValid,
  output logic                  exRegWrite,
  output logic                  exMemRead,
  output logic                  exMemWrite
);

  // id_ex_t is laid out with the package widths; overrides must match them.
  id_ex_t            r_idEx;
  id_ex_t            w_idNext;
  fwd_sel_e          w_selRs;
  fwd_sel_e          w_selRt;
  logic [DATA_W-1:0] w_fwdRs;
  logic [DATA_W-1:0] w_fwdRt;
  logic              w_stall;

  assign w_stall = !exHold && idValid && r_idEx.valid && r_idEx.memRead &&
                   (r_idEx.dest != REG_ZERO) &&
                   ((r_idEx.dest == idRs) || (r_idEx.dest == idRt));

  always_comb begin
    w_idNext = '0;
    if (idValid) begin
      w_idNext.valid    = 1'b1;
      w_idNext.regWrite = idRegWrite;
      w_idNext.memRead  = idMemRead;
      w_idNext.memWrite = idMemWrite;
      w_idNext.aluOp    = idAluOp;
      w_idNext.aluSrc   = idAluSrc;
      w_idNext.rs       = idRs;
      w_idNext.rt       = idRt;
      w_idNext.dest     = idDest;
      w_idNext.rsData   = idRsData;
      w_idNext.rtData   = idRtData;
      w_idNext.imm      = idImm;
    end
  end

  // Bubbles are written as all-zero so the ALU sees quiet operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idEx <= '0;
    end else if (!exHold) begin
      if (flush || w_stall) begin
        r_idEx <= '0;
      end else begin
        r_idEx <= w_idNext;
      end
    end
  end

  forwarding_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwdRs (
    .src           (r_idEx.rs),
    .exMemRegWrite (exMemRegWrite),
    .exMemDest     (exMemDest),
    .memWbRegWrite (memWbRegWrite),
    .memWbDest     (memWbDest),
    .sel           (w_selRs)
  );

  forwarding_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwdRt (
    .src           (r_idEx.rt),
    .exMemRegWrite (exMemRegWrite),
    .exMemDest     (exMemDest),
    .memWbRegWrite (memWbRegWrite),
    .memWbDest     (memWbDest),
    .sel           (w_selRt)
  );

  always_comb begin
    w_fwdRs = r_idEx.rsData;
    case (w_selRs)
      FWD_EXMEM: w_fwdRs = exMemResult;
      FWD_MEMWB: w_fwdRs = memWbResult;
      default:   w_fwdRs = r_idEx.rsData;
    endcase
  end

  always_comb begin
    w_fwdRt = r_idEx.rtData;
    case (w_selRt)
      FWD_EXMEM: w_fwdRt = exMemResult;
      FWD_MEMWB: w_fwdRt = memWbResult;
      default:   w_fwdRt = r_idEx.rtData;
    endcase
  end

  assign stall       = w_stall;
  assign aluInA      = w_fwdRs;
  assign aluInB      = r_idEx.aluSrc ? r_idEx.imm : w_fwdRt;
  assign exStoreData = w_fwdRt;
  assign aluOp       = r_idEx.aluOp;
  assign exDest      = r_idEx.dest;
  assign exValid     = r_idEx.valid;
  assign exRegWrite  = r_idEx.regWrite;
  assign exMemRead   = r_idEx.memRead;
  assign exMemWrite  = r_idEx.memWrite;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
// ============================================================================
//  Module      : tb_id_ex_operand_stage
//  Description : Scoreboard bench for id_ex_operand_stage against a
//                behavioural pipeline-register model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_id_ex_operand_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          idValid, idAluSrc, idRegWrite, idMemRead, idMemWrite;
  logic [AW-1:0] idRs, idRt, idDest;
  logic [DW-1:0] idRsData, idRtData, idImm;
  logic [2:0]    idAluOp;
  logic          flush, exHold;
  logic          exMemRegWrite, memWbRegWrite;
  logic [AW-1:0] exMemDest, memWbDest;
  logic [DW-1:0] exMemResult, memWbResult;
  logic          stall, exValid, exRegWrite, exMemRead, exMemWrite;
  logic [DW-1:0] aluInA, aluInB, exStoreData;
  logic [2:0]    aluOp;
  logic [AW-1:0] exDest;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .idValid(idValid), .idRs(idRs), .idRt(idRt),
    .idDest(idDest), .idRsData(idRsData), .idRtData(idRtData), .idImm(idImm),
    .idAluOp(idAluOp), .idAluSrc(idAluSrc), .idRegWrite(idRegWrite),
    .idMemRead(idMemRead), .idMemWrite(idMemWrite), .flush(flush),
    .exHold(exHold), .exMemRegWrite(exMemRegWrite), .exMemDest(exMemDest),
    .exMemResult(exMemResult), .memWbRegWrite(memWbRegWrite),
    .memWbDest(memWbDest), .memWbResult(memWbResult), .stall(stall),
    .aluInA(aluInA), .aluInB(aluInB), .aluOp(aluOp), .exStoreData(exStoreData),
    .exDest(exDest), .exValid(exValid), .exRegWrite(exRegWrite),
    .exMemRead(exMemRead), .exMemWrite(exMemWrite)
  );

  typedef struct {
    int            tag;
    logic          stall, v, rw, mr, mw;
    logic [DW-1:0] a, b, sd;
    logic [2:0]    op;
    logic [AW-1:0] dest;
    bit            dataKnown;
  } exp_t;

  exp_t q[$];
  exp_t mon;
  int   checks = 0;
  int   errors = 0;
  int   stepNo = 0;

  // Model of the instruction currently sitting in EX.
  bit            mKnown = 0, mDataKnown = 0;
  logic          mValid, mRegWrite, mMemRead, mMemWrite, mAluSrc;
  logic [2:0]    mAluOp;
  logic [AW-1:0] mRs, mRt, mDest;
  logic [DW-1:0] mRsData, mRtData, mImm;

  function automatic logic [DW-1:0] freshest(input logic [AW-1:0] src, input logic [DW-1:0] rf);
    if (src != 0 && exMemRegWrite && exMemDest == src) return exMemResult;
    if (src != 0 && memWbRegWrite && memWbDest == src) return memWbResult;
    return rf;
  endfunction

  task automatic chk(input string nm, input int tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d actual %h expected %h", nm, tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon = q.pop_front();
      chk("stall", mon.tag, {31'b0, stall}, {31'b0, mon.stall});
      chk("exValid", mon.tag, {31'b0, exValid}, {31'b0, mon.v});
      chk("exRegWrite", mon.tag, {31'b0, exRegWrite}, {31'b0, mon.rw});
      chk("exMemRead", mon.tag, {31'b0, exMemRead}, {31'b0, mon.mr});
      chk("exMemWrite", mon.tag, {31'b0, exMemWrite}, {31'b0, mon.mw});
      chk("exDest", mon.tag, {27'b0, exDest}, {27'b0, mon.dest});
      if (mon.dataKnown) begin
        chk("aluInA", mon.tag, aluInA, mon.a);
        chk("aluInB", mon.tag, aluInB, mon.b);
        chk("exStoreData", mon.tag, exStoreData, mon.sd);
        chk("aluOp", mon.tag, {29'b0, aluOp}, {29'b0, mon.op});
      end
    end
  end

  // Predict this cycle's outputs, then advance the model across the edge.
  task automatic step();
    exp_t          e;
    logic [DW-1:0] rtVal;
    logic          stallNow;
    stallNow = !exHold && idValid && mValid && mMemRead && mDest != 0 &&
               (mDest == idRs || mDest == idRt);
    if (mKnown) begin
      rtVal       = freshest(mRt, mRtData);
      e.tag       = stepNo;
      e.stall     = stallNow;
      e.v         = mValid;
      e.rw        = mRegWrite;
      e.mr        = mMemRead;
      e.mw        = mMemWrite;
      e.dest      = mDest;
      e.a         = freshest(mRs, mRsData);
      e.b         = mAluSrc ? mImm : rtVal;
      e.sd        = rtVal;
      e.op        = mAluOp;
      e.dataKnown = mDataKnown;
      q.push_back(e);
    end
    @(posedge clk);
    if (rst) begin
      {mValid, mRegWrite, mMemRead, mMemWrite, mAluSrc} = '0;
      mAluOp = '0; mRs = '0; mRt = '0; mDest = '0;
      mRsData = '0; mRtData = '0; mImm = '0;
      mKnown = 1; mDataKnown = 1;
    end else if (exHold) begin
      // frozen
    end else if (flush || stallNow || !idValid) begin
      {mValid, mRegWrite, mMemRead, mMemWrite} = '0;
      mDest = '0;
      mDataKnown = 0;
    end else begin
      mValid = 1; mRegWrite = idRegWrite; mMemRead = idMemRead; mMemWrite = idMemWrite;
      mAluSrc = idAluSrc; mAluOp = idAluOp; mRs = idRs; mRt = idRt; mDest = idDest;
      mRsData = idRsData; mRtData = idRtData; mImm = idImm;
      mDataKnown = 1;
    end
    stepNo++;
    #1;
  endtask

  task automatic setId(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic [AW-1:0] dst, input logic [DW-1:0] rsD, input logic [DW-1:0] rtD,
                       input logic [DW-1:0] imm, input logic [2:0] op, input logic src,
                       input logic rw, input logic mr, input logic mw);
    idValid = v; idRs = rs; idRt = rt; idDest = dst; idRsData = rsD; idRtData = rtD;
    idImm = imm; idAluOp = op; idAluSrc = src; idRegWrite = rw; idMemRead = mr; idMemWrite = mw;
  endtask

  task automatic setFwd(input logic emW, input logic [AW-1:0] emD, input logic [DW-1:0] emR,
                        input logic mwW, input logic [AW-1:0] mwD, input logic [DW-1:0] mwR);
    exMemRegWrite = emW; exMemDest = emD; exMemResult = emR;
    memWbRegWrite = mwW; memWbDest = mwD; memWbResult = mwR;
  endtask

  initial begin
    rst = 1; flush = 0; exHold = 0;
    setFwd(0, 0, 0, 0, 0, 0);
    setId(1, 3, 4, 7, 32'h99, 32'h55, 32'h1234, 3'b001, 0, 1, 1, 1);
    step(); step();
    rst = 0;

    // EX/MEM forward to rs, then no forward from r0
    setId(1, 3, 4, 6, 32'h99, 32'h44, 0, 3'b000, 0, 1, 0, 0); step();
    setId(1, 0, 0, 6, 32'h0, 32'h0, 0, 3'b000, 0, 1, 0, 0);
    setFwd(1, 3, 32'h10, 0, 0, 0); step();
    setId(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    setFwd(1, 0, 32'hFF, 1, 0, 32'hEE); step();

    // EX/MEM wins over MEM/WB
    setFwd(0, 0, 0, 0, 0, 0);
    setId(1, 1, 5, 6, 32'h1, 32'h77, 0, 3'b001, 0, 1, 0, 0); step();
    setId(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    setFwd(1, 5, 32'hA, 1, 5, 32'hB); step();

    // load-use: stall, bubble, reload, then MEM/WB forward
    setFwd(0, 0, 0, 0, 0, 0);
    setId(1, 1, 1, 2, 32'h8, 32'h0, 32'h4, 3'b000, 1, 1, 1, 0); step();
    setId(1, 2, 3, 4, 32'h5, 32'h6, 0, 3'b000, 0, 1, 0, 0); step();
    step();
    setId(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    setFwd(0, 0, 0, 1, 2, 32'hB); step();

    // flush with stall, then hold with flush
    setFwd(0, 0, 0, 0, 0, 0);
    setId(1, 1, 1, 2, 32'h8, 32'h0, 32'h4, 3'b000, 1, 1, 1, 0); step();
    setId(1, 2, 2, 4, 32'h5, 32'h6, 0, 3'b010, 0, 1, 0, 0); flush = 1; step();
    flush = 0;
    setId(1, 1, 7, 9, 32'h31, 32'h32, 0, 3'b011, 0, 1, 0, 1); step();
    setId(1, 6, 6, 8, 32'h61, 32'h62, 0, 3'b100, 0, 1, 1, 0); exHold = 1; flush = 1; step(); step();
    exHold = 0; flush = 0;
    setId(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0); step();

    // immediate operand with forwarded store data
    setId(1, 5, 5, 3, 32'h11, 32'h22, 32'hFFFFFFFC, 3'b000, 1, 0, 0, 1); step();
    setId(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    setFwd(1, 5, 32'hCAFE, 0, 0, 0); step();

    for (int i = 0; i < 500; i++) begin
      rst    = ($urandom_range(0, 63) == 0);
      flush  = ($urandom_range(0, 9) == 0);
      exHold = ($urandom_range(0, 9) == 0);
      setId($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 3'($urandom_range(0, 4)),
            1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0, 1'($urandom));
      setFwd(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
             1'($urandom), 5'($urandom_range(0, 3)), $urandom);
      step();
    end
    rst = 0; flush = 0; exHold = 0;

    @(negedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual %0d expected 0 pending", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
